// File: rtl/fp_norm_seq.sv
// fp_norm_seq: multi-cycle mantissa normalizer between add/mul and pack/round.
// Ports: clk, rst_n, start, mant_in, exp_in -> busy, done, mant_out, exp_out,
//        shift_ctrl (0=left,2=right,1=hold), zero, underflow, overflow.
module fp_norm_seq #(
   parameter int MANT_W = 25,
   parameter int EXP_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [MANT_W-1:0] mant_in,
   input  logic [EXP_W-1:0]  exp_in,
   output logic              busy,
   output logic              done,
   output logic [MANT_W-1:0] mant_out,
   output logic [EXP_W-1:0]  exp_out,
   output logic [1:0]        shift_ctrl,
   output logic              zero,
   output logic              underflow,
   output logic              overflow
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_NORM = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [1:0] SH_LEFT  = 2'd0;
   localparam logic [1:0] SH_HOLD  = 2'd1;
   localparam logic [1:0] SH_RIGHT = 2'd2;

   localparam logic [EXP_W-1:0] EMAX    = '1;
   localparam logic [EXP_W-1:0] EMAX_M1 = EMAX - 1'b1;
   localparam logic [EXP_W-1:0] EXP_ONE = {{(EXP_W-1){1'b0}}, 1'b1};
   localparam logic [EXP_W-1:0] EXP_ZRO = '0;
   localparam logic [MANT_W-1:0] MANT_ZRO = '0;

   logic [1:0]        state_q, state_d;
   logic [MANT_W-1:0] mant_q, mant_d;
   logic [EXP_W-1:0]  exp_q, exp_d;
   logic              zero_q, zero_d;
   logic              uflow_q, uflow_d;
   logic              oflow_q, oflow_d;
   logic [1:0]        shift_d;

   always_comb begin
      state_d = state_q;
      mant_d  = mant_q;
      exp_d   = exp_q;
      zero_d  = zero_q;
      uflow_d = uflow_q;
      oflow_d = oflow_q;
      shift_d = SH_HOLD;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               mant_d  = mant_in;
               exp_d   = exp_in;
               zero_d  = 1'b0;
               uflow_d = 1'b0;
               oflow_d = 1'b0;
               state_d = S_NORM;
            end
         end
         S_NORM: begin
            // Priority order matters: inf/NaN and zero win over shifting.
            if (exp_q == EMAX) begin
               state_d = S_DONE;
            end else if (mant_q == MANT_ZRO) begin
               exp_d   = EXP_ZRO;
               zero_d  = 1'b1;
               state_d = S_DONE;
            end else if (mant_q[MANT_W-1]) begin
               if (exp_q == EMAX_M1) begin
                  exp_d   = EMAX;
                  mant_d  = MANT_ZRO;
                  oflow_d = 1'b1;
                  state_d = S_DONE;
               end else begin
                  // Carry out lands on the hidden bit, so one right
                  // shift always finishes normalization.
                  shift_d = SH_RIGHT;
                  mant_d  = mant_q >> 1;
                  exp_d   = exp_q + 1'b1;
               end
            end else if (mant_q[MANT_W-2]) begin
               state_d = S_DONE;
            end else if (exp_q > EXP_ONE) begin
               shift_d = SH_LEFT;
               mant_d  = mant_q << 1;
               exp_d   = exp_q - 1'b1;
            end else begin
               exp_d   = EXP_ZRO;
               uflow_d = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         mant_q  <= '0;
         exp_q   <= '0;
         zero_q  <= 1'b0;
         uflow_q <= 1'b0;
         oflow_q <= 1'b0;
      end else begin
         state_q <= state_d;
         mant_q  <= mant_d;
         exp_q   <= exp_d;
         zero_q  <= zero_d;
         uflow_q <= uflow_d;
         oflow_q <= oflow_d;
      end
   end

   assign busy       = (state_q != S_IDLE);
   assign done       = (state_q == S_DONE);
   assign mant_out   = mant_q;
   assign exp_out    = exp_q;
   assign shift_ctrl = shift_d;
   assign zero       = zero_q;
   assign underflow  = uflow_q;
   assign overflow   = oflow_q;

endmodule

// File: tb/tb_fp_norm_seq.sv
// tb_fp_norm_seq: directed vector table plus abort / ignored-start sequences.
// Drives fp_norm_seq with MANT_W=25, EXP_W=8.
module tb_fp_norm_seq;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [24:0] mant_in;
   logic [7:0]  exp_in;
   logic        busy;
   logic        done;
   logic [24:0] mant_out;
   logic [7:0]  exp_out;
   logic [1:0]  shift_ctrl;
   logic        zero;
   logic        underflow;
   logic        overflow;

   int checks;
   int failures;
   int done_cnt;

   fp_norm_seq #(.MANT_W(25), .EXP_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .mant_in    (mant_in),
      .exp_in     (exp_in),
      .busy       (busy),
      .done       (done),
      .mant_out   (mant_out),
      .exp_out    (exp_out),
      .shift_ctrl (shift_ctrl),
      .zero       (zero),
      .underflow  (underflow),
      .overflow   (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) done_cnt <= done_cnt;
      else if (done) done_cnt <= done_cnt + 1;
   end

   typedef struct {
      logic [24:0] m;
      logic [7:0]  e;
      int          nl;
      int          nr;
      logic [24:0] xm;
      logic [7:0]  xe;
      logic        xz;
      logic        xu;
      logic        xo;
   } vec_t;

   vec_t vt[11];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic run_op(input vec_t v, input string tag);
      int n;
      int nl;
      int nr;
      logic [24:0] hm;
      @(negedge clk);
      start   = 1'b1;
      mant_in = v.m;
      exp_in  = v.e;
      @(posedge clk);
      #1;
      start   = 1'b0;
      mant_in = '0;
      exp_in  = '0;
      check({tag, " busy_after_start"}, {31'd0, busy}, 32'd1);
      n  = 0;
      nl = 0;
      nr = 0;
      while (!done && n < 200) begin
         if (shift_ctrl == 2'd0) nl++;
         else if (shift_ctrl == 2'd2) nr++;
         @(posedge clk);
         #1;
         n++;
      end
      check({tag, " latency"}, n, v.nl + v.nr + 1);
      check({tag, " left_shifts"}, nl, v.nl);
      check({tag, " right_shifts"}, nr, v.nr);
      check({tag, " mant"}, {7'd0, mant_out}, {7'd0, v.xm});
      check({tag, " exp"}, {24'd0, exp_out}, {24'd0, v.xe});
      check({tag, " zero"}, {31'd0, zero}, {31'd0, v.xz});
      check({tag, " underflow"}, {31'd0, underflow}, {31'd0, v.xu});
      check({tag, " overflow"}, {31'd0, overflow}, {31'd0, v.xo});
      check({tag, " busy_in_done"}, {31'd0, busy}, 32'd1);
      hm = mant_out;
      @(posedge clk);
      #1;
      check({tag, " done_pulse"}, {31'd0, done}, 32'd0);
      check({tag, " idle_busy"}, {31'd0, busy}, 32'd0);
      check({tag, " held_mant"}, {7'd0, mant_out}, {7'd0, hm});
   endtask

   initial begin
      int d0;
      checks   = 0;
      failures = 0;
      done_cnt = 0;
      start    = 1'b0;
      mant_in  = '0;
      exp_in   = '0;

      vt[0]  = '{25'h0800000, 8'd127, 0,  0, 25'h0800000, 8'd127, 0, 0, 0};
      vt[1]  = '{25'h1000000, 8'd127, 0,  1, 25'h0800000, 8'd128, 0, 0, 0};
      vt[2]  = '{25'h0000001, 8'd127, 23, 0, 25'h0800000, 8'd104, 0, 0, 0};
      vt[3]  = '{25'h0000100, 8'd3,   2,  0, 25'h0000400, 8'd0,   0, 1, 0};
      vt[4]  = '{25'h1800000, 8'd254, 0,  0, 25'h0000000, 8'd255, 0, 0, 1};
      vt[5]  = '{25'h0000000, 8'd90,  0,  0, 25'h0000000, 8'd0,   1, 0, 0};
      vt[6]  = '{25'h0000123, 8'd255, 0,  0, 25'h0000123, 8'd255, 0, 0, 0};
      vt[7]  = '{25'h1FFFFFF, 8'd10,  0,  1, 25'h0FFFFFF, 8'd11,  0, 0, 0};
      vt[8]  = '{25'h0400000, 8'd1,   0,  0, 25'h0400000, 8'd0,   0, 1, 0};
      vt[9]  = '{25'h0400000, 8'd2,   1,  0, 25'h0800000, 8'd1,   0, 0, 0};
      vt[10] = '{25'h0800000, 8'd0,   0,  0, 25'h0800000, 8'd0,   0, 0, 0};

      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst busy", {31'd0, busy}, 32'd0);
      check("rst done", {31'd0, done}, 32'd0);
      check("rst mant", {7'd0, mant_out}, 32'd0);
      check("rst exp", {24'd0, exp_out}, 32'd0);
      check("rst shift_ctrl", {30'd0, shift_ctrl}, 32'd1);
      check("rst flags", {29'd0, zero, underflow, overflow}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Table vectors; each start lands in the cycle after the previous
      // done, so the table also exercises back-to-back operation.
      for (int i = 0; i < 11; i++) begin
         run_op(vt[i], $sformatf("v%0d", i));
      end

      // Ignored start mid-run, then asynchronous abort at shift 10.
      d0 = done_cnt;
      @(negedge clk);
      start   = 1'b1;
      mant_in = 25'h0000001;
      exp_in  = 8'd127;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int c = 0; c < 10; c++) begin
         if (c == 5) begin
            start   = 1'b1;
            mant_in = 25'h0800000;
            exp_in  = 8'd50;
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      check("mid busy", {31'd0, busy}, 32'd1);
      check("mid mant", {7'd0, mant_out}, 32'h400);
      check("mid exp", {24'd0, exp_out}, 32'd117);
      rst_n = 1'b0;
      #1;
      check("abort busy", {31'd0, busy}, 32'd0);
      check("abort mant", {7'd0, mant_out}, 32'd0);
      check("abort exp", {24'd0, exp_out}, 32'd0);
      check("abort shift_ctrl", {30'd0, shift_ctrl}, 32'd1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      check("abort no_done", done_cnt, d0);
      check("abort idle", {31'd0, busy}, 32'd0);
      run_op(vt[0], "post_reset_t1");
      run_op(vt[1], "b2b_a");
      run_op(vt[3], "b2b_b");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
